// File: rtl/life_pkg.sv
// Shared types and constants for the Conway life board.
// The rule masks are indexed by the live-neighbour count n (0..8).
package life_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        COMMIT = 2'd2
    } life_state_t;

    localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
    localparam logic [8:0] SURVIVE_MASK = 9'b000001100;
    localparam int         GEN_W        = 16;

    function automatic logic [3:0] count3(input logic [2:0] v);
        return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]};
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation rule for one row.
// The caller supplies the rows above and below, already wrapped or zeroed.
module life_row_next
    import life_pkg::*;
#(
    parameter int COLS = 8,
    parameter int WRAP = 1
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] current,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] next_row
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int CL = (c == 0) ? COLS - 1 : c - 1;
        localparam int CR = (c == COLS - 1) ? 0 : c + 1;
        // Without wrap, the off-grid column contributes no neighbours.
        localparam bit EL = (WRAP == 0) && (c == 0);
        localparam bit ER = (WRAP == 0) && (c == COLS - 1);

        logic [2:0] lft, mid, rgt;
        logic [3:0] n;

        assign lft = EL ? 3'b000 : {above[CL], current[CL], below[CL]};
        assign mid = {above[c], 1'b0, below[c]};
        assign rgt = ER ? 3'b000 : {above[CR], current[CR], below[CR]};
        assign n   = count3(lft) + count3(mid) + count3(rgt);

        assign next_row[c] = BIRTH_MASK[n] | (current[c] & SURVIVE_MASK[n]);
    end

endmodule

// File: rtl/life_board.sv
// ROWS x COLS life board: row loads, row-sequential sweep into a next buffer,
// then a single-edge commit of the whole grid.
module life_board
    import life_pkg::*;
#(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int WRAP = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_r,
    input  logic [$clog2(ROWS)-1:0]  r_select,
    input  logic [COLS-1:0]          r_val,
    input  logic                     step,
    output logic                     busy,
    output logic                     done,
    output logic [GEN_W-1:0]         generation,
    output logic [ROWS*COLS-1:0]     cells
);

    localparam int              RW     = $clog2(ROWS);
    localparam logic [RW-1:0]   LAST   = RW'(ROWS - 1);
    localparam logic [RW:0]     ROWS_L = (RW + 1)'(ROWS);

    life_state_t           state;
    logic [RW-1:0]         rc;
    logic [RW-1:0]         rc_up, rc_dn;
    logic [ROWS*COLS-1:0]  nbuf;
    logic [COLS-1:0]       row_above, row_cur, row_below, row_next;
    logic                  row_ok;

    assign busy   = (state != IDLE);
    assign row_ok = ({1'b0, r_select} < ROWS_L);
    assign rc_up  = rc - 1'b1;
    assign rc_dn  = rc + 1'b1;

    // Neighbour rows come from the committed grid, never the next buffer.
    always_comb begin
        row_cur   = cells[rc*COLS +: COLS];
        row_above = '0;
        row_below = '0;
        if (rc == '0) begin
            if (WRAP != 0) row_above = cells[(ROWS-1)*COLS +: COLS];
        end else begin
            row_above = cells[rc_up*COLS +: COLS];
        end
        if (rc == LAST) begin
            if (WRAP != 0) row_below = cells[0 +: COLS];
        end else begin
            row_below = cells[rc_dn*COLS +: COLS];
        end
    end

    life_row_next #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_next (
        .above    (row_above),
        .current  (row_cur),
        .below    (row_below),
        .next_row (row_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rc         <= '0;
            nbuf       <= '0;
            cells      <= '0;
            generation <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A load in the same cycle as step lands before the sweep reads it.
                    if (load_r && row_ok) cells[r_select*COLS +: COLS] <= r_val;
                    if (step) begin
                        state <= SWEEP;
                        rc    <= '0;
                    end
                end
                SWEEP: begin
                    nbuf[rc*COLS +: COLS] <= row_next;
                    if (rc == LAST) state <= COMMIT;
                    else            rc    <= rc_dn;
                end
                COMMIT: begin
                    cells      <= nbuf;
                    generation <= generation + 1'b1;
                    done       <= 1'b1;
                    rc         <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_board.sv
// Directed bench for life_board: one wrapping and one non-wrapping 8x8 board
// driven in lockstep; expected grids are hand-derived constants.
module tb_life_board;

    localparam int COLS = 8;
    localparam int ROWS = 8;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 load_r = 1'b0;
    logic [2:0]           r_select = '0;
    logic [COLS-1:0]      r_val = '0;
    logic                 step = 1'b0;

    logic                 busy_w, done_w, busy_z, done_z;
    logic [15:0]          gen_w, gen_z;
    logic [ROWS*COLS-1:0] cells_w, cells_z;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;

    always #5 clk = ~clk;

    life_board #(.COLS(COLS), .ROWS(ROWS), .WRAP(1)) dut_w (
        .clk(clk), .reset_n(reset_n), .load_r(load_r), .r_select(r_select),
        .r_val(r_val), .step(step), .busy(busy_w), .done(done_w),
        .generation(gen_w), .cells(cells_w)
    );

    life_board #(.COLS(COLS), .ROWS(ROWS), .WRAP(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .load_r(load_r), .r_select(r_select),
        .r_val(r_val), .step(step), .busy(busy_z), .done(done_z),
        .generation(gen_z), .cells(cells_z)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic do_reset();
        load_r = 1'b0; step = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_row(input logic [2:0] r, input logic [7:0] v);
        load_r = 1'b1; r_select = r; r_val = v;
        @(negedge clk);
        load_r = 1'b0;
    endtask

    // Issues step, returns the number of busy cycles and done at the first idle cycle.
    task automatic run_step(output int nb, output logic d);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        nb = 0;
        while (busy_w === 1'b1 && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        d = done_w;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (cells_w !== 64'h0) $display("FAIL reset_cells got=%h exp=0", cells_w); else pass_cnt++;
        total++; if (gen_w !== 16'h0) $display("FAIL reset_gen got=%h exp=0", gen_w); else pass_cnt++;
        total++; if (busy_w !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_w); else pass_cnt++;
        total++; if (done_w !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_w); else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
        load_row(3'd5, 8'hA5);
        total++; if (cells_w[47:40] !== 8'hA5) $display("FAIL load_row5 got=%h exp=a5", cells_w[47:40]); else pass_cnt++;
        total++; if (cells_w !== 64'h0000_A500_0000_0000) $display("FAIL load_grid got=%h exp=0000a50000000000", cells_w); else pass_cnt++;
    endtask

    task automatic test_blinker();
        int nb; logic d;
        do_reset();
        load_row(3'd3, 8'b00011100);
        run_step(nb, d);
        total++; if (nb !== 9) $display("FAIL blink_busy_cycles got=%0d exp=9", nb); else pass_cnt++;
        total++; if (d !== 1'b1) $display("FAIL blink_done got=%b exp=1", d); else pass_cnt++;
        total++; if (cells_w !== BLINK_V) $display("FAIL blink_gen1 got=%h exp=%h", cells_w, BLINK_V); else pass_cnt++;
        total++; if (gen_w !== 16'd1) $display("FAIL blink_count1 got=%0d exp=1", gen_w); else pass_cnt++;
        // Back-to-back: step is issued in the cycle done is high.
        run_step(nb, d);
        total++; if (nb !== 9) $display("FAIL b2b_busy_cycles got=%0d exp=9", nb); else pass_cnt++;
        total++; if (cells_w !== BLINK_H) $display("FAIL blink_gen2 got=%h exp=%h", cells_w, BLINK_H); else pass_cnt++;
        total++; if (gen_w !== 16'd2) $display("FAIL blink_count2 got=%0d exp=2", gen_w); else pass_cnt++;
        @(negedge clk);
        total++; if (done_w !== 1'b0) $display("FAIL done_one_cycle got=%b exp=0", done_w); else pass_cnt++;
    endtask

    task automatic test_step_ignored_busy();
        int nb; logic d;
        step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);   // step still high while busy; must not queue
        step = 1'b0;
        nb = 0;
        while (busy_w === 1'b1 && nb < 40) begin nb++; @(negedge clk); end
        repeat (4) @(negedge clk);
        total++; if (busy_w !== 1'b0) $display("FAIL busy_step_busy got=%b exp=0", busy_w); else pass_cnt++;
        total++; if (gen_w !== 16'd3) $display("FAIL busy_step_gen got=%0d exp=3", gen_w); else pass_cnt++;
        total++; if (cells_w !== BLINK_V) $display("FAIL busy_step_cells got=%h exp=%h", cells_w, BLINK_V); else pass_cnt++;
    endtask

    task automatic test_still_life();
        int nb; logic d;
        do_reset();
        load_row(3'd0, 8'h03);
        load_row(3'd1, 8'h03);
        for (int i = 0; i < 3; i++) run_step(nb, d);
        total++; if (cells_w !== 64'h0303) $display("FAIL still_wrap got=%h exp=0303", cells_w); else pass_cnt++;
        total++; if (cells_z !== 64'h0303) $display("FAIL still_nowrap got=%h exp=0303", cells_z); else pass_cnt++;
        total++; if (gen_w !== 16'd3) $display("FAIL still_gen got=%0d exp=3", gen_w); else pass_cnt++;
    endtask

    task automatic test_edge();
        int nb; logic d;
        do_reset();
        load_row(3'd3, 8'b10000011);
        run_step(nb, d);
        total++; if (cells_w !== 64'h0000_0001_0101_0000) $display("FAIL edge_wrap got=%h exp=0000000101010000", cells_w); else pass_cnt++;
        total++; if (cells_z !== 64'h0) $display("FAIL edge_nowrap got=%h exp=0", cells_z); else pass_cnt++;
        total++; if (gen_z !== 16'd1) $display("FAIL edge_nowrap_gen got=%0d exp=1", gen_z); else pass_cnt++;
    endtask

    task automatic test_load_collision();
        int nb; logic d;
        do_reset();
        load_row(3'd3, 8'b00011100);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load_r = 1'b1; r_select = 3'd0; r_val = 8'hFF;
        @(negedge clk);
        load_r = 1'b0;
        total++; if (cells_w[7:0] !== 8'h00) $display("FAIL busy_load_visible got=%h exp=00", cells_w[7:0]); else pass_cnt++;
        nb = 0;
        while (busy_w === 1'b1 && nb < 40) begin nb++; @(negedge clk); end
        total++; if (cells_w !== BLINK_V) $display("FAIL busy_load_dropped got=%h exp=%h", cells_w, BLINK_V); else pass_cnt++;
        // Load and step at the same edge from an empty grid.
        do_reset();
        load_r = 1'b1; r_select = 3'd3; r_val = 8'b00011100; step = 1'b1;
        @(negedge clk);
        load_r = 1'b0; step = 1'b0;
        nb = 0;
        while (busy_w === 1'b1 && nb < 40) begin nb++; @(negedge clk); end
        total++; if (nb !== 9) $display("FAIL same_edge_busy got=%0d exp=9", nb); else pass_cnt++;
        total++; if (cells_w !== BLINK_V) $display("FAIL same_edge_cells got=%h exp=%h", cells_w, BLINK_V); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        int nb; logic d; int dones;
        do_reset();
        load_row(3'd3, 8'b00011100);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++; if (cells_w !== 64'h0) $display("FAIL midrst_cells got=%h exp=0", cells_w); else pass_cnt++;
        total++; if (busy_w !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy_w); else pass_cnt++;
        total++; if (gen_w !== 16'd0) $display("FAIL midrst_gen got=%0d exp=0", gen_w); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_w === 1'b1) dones++;
        end
        total++; if (dones !== 0) $display("FAIL midrst_no_done got=%0d exp=0", dones); else pass_cnt++;
        load_row(3'd3, 8'b00011100);
        run_step(nb, d);
        total++; if (cells_w !== BLINK_V) $display("FAIL midrst_after got=%h exp=%h", cells_w, BLINK_V); else pass_cnt++;
        total++; if (gen_w !== 16'd1) $display("FAIL midrst_after_gen got=%0d exp=1", gen_w); else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_blinker();
        test_step_ignored_busy();
        test_still_life();
        test_edge();
        test_load_collision();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/life_board.md
# life_board

Parametrised cellular-automaton board for the State-Automata datapath. It holds a ROWS×COLS grid of one-bit cells and accepts row-wise loads from the host or input FSM. On a `step` command it computes the next Conway generation (B3/S23) with a row-sequential sweep, then commits the whole grid at once. The flat `cells` output feeds the display/VGA path, and its bit layout is unchanged from the fixed 8×8 board.

## Interface
Parameters:
- `COLS`, 8: cells per row, ≥3.
- `ROWS`, 8: number of rows, ≥3.
- `WRAP`, 1: 1 = toroidal edges; 0 = cells outside the grid read as dead.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_r`  in  1  row write strobe.
- `r_select`  in  $clog2(ROWS)  row index for the write.
- `r_val`  in  COLS  row data; bit c is column c.
- `step`  in  1  request one generation.
- `busy`  out  1  high while a generation is in progress.
- `done`  out  1  one-cycle pulse when the new generation is committed.
- `generation`  out  16  count of committed generations.
- `cells`  out  ROWS*COLS  current grid; row r is `cells[r*COLS +: COLS]`.

## Operation
- Reset, asynchronous: `cells`=0, next-buffer=0, `generation`=0, `busy`=0, `done`=0, row counter=0, state=IDLE. Asserting reset mid-sweep aborts the sweep with no partial commit.
- States:
  - IDLE: `busy`=0. `step`=1 → SWEEP, row counter=0.
  - SWEEP: at each edge, next-buffer row `rc` is written with the rule result for row `rc`, computed from the unchanged `cells`. When `rc`=ROWS-1 → COMMIT; otherwise `rc`+1.
  - COMMIT: at the edge, `cells`←next-buffer, `generation`+1 (wraps 0xFFFF→0), `done`←1, `busy`←0. Then → IDLE.
- Rule per cell:
  - Neighbour count n is 0..8, held in 4 bits.
  - Alive next = (n==3) | (alive & n==2).
  - WRAP=1: neighbour indices are taken mod ROWS / mod COLS.
  - WRAP=0: out-of-range neighbours count as 0.
- Loads:
  - In IDLE, `load_r` writes `r_val` to row `r_select`.
  - `r_select` ≥ ROWS is ignored.
  - `load_r` while `busy`=1, or in the COMMIT cycle, is dropped silently. The grid is never modified mid-sweep except by the commit.
- Simultaneous `load_r` and `step` in IDLE: the load is applied at the same edge, the step is accepted, and the sweep sees the loaded row.
- `step` while `busy`=1 is ignored; it is not queued.
- `done` is high exactly one cycle and is registered.

## Timing
- The `step` edge is E0.
- `busy`=1 from after E0 until after the commit edge E(ROWS+1), i.e. for ROWS+1 cycles.
- New `cells`, the incremented `generation`, and `done`=1 are all visible in the cycle after E(ROWS+1).
- A new `step` may be asserted in the cycle where `done`=1, because the block is already in IDLE. Back-to-back generations therefore take ROWS+2 cycles each.
- A load is visible on `cells` one cycle after its edge.
- No combinational path exists from inputs to outputs.

## Structure
- Package `life_pkg` holds:
  - the state enum `life_state_t` (IDLE, SWEEP, COMMIT);
  - constants `BIRTH_MASK` = 9'b000001000 and `SURVIVE_MASK` = 9'b000001100, indexed by n;
  - the generation width constant `GEN_W` = 16.
- Sub-module `life_row_next`:
  - purely combinational; parameters COLS and WRAP;
  - inputs: above, current and below rows; output: next row.
  - The top level selects the above/below rows by `rc`±1, wrapped or zeroed per WRAP.
- The top level owns the FSM, the row counter, the next-buffer and the load logic.

## Test plan
All cases use COLS=ROWS=8 unless noted.
- Reset: hold `reset_n`=0 → `cells`=0, `generation`=0, `busy`=0, `done`=0. Load row 5=8'hA5 → `cells[47:40]`=8'hA5 one cycle later.
- Blinker:
  - Stimulus: row 3=8'b00011100, then `step`.
  - Required: `busy` high 9 cycles, then `done` pulses once; rows 2, 3 and 4 each = 8'b00001000 and all other rows 0; `generation`=1.
  - A second `step` restores the original pattern with `generation`=2.
- Still life: rows 0 and 1 = 8'h03, then 3 steps → grid unchanged, `generation`=3.
- Edge mode, row 3=8'b10000011, one step:
  - WRAP=1 → rows 2, 3 and 4 = 8'b00000001.
  - WRAP=0 → entire grid = 0.
- Load collisions:
  - `load_r` with row 0=8'hFF at sweep cycle 3 → dropped; the result equals the case without the load.
  - `load_r` and `step` at the same edge in IDLE → the loaded row takes part in the generation.
- Reset mid-sweep: drop `reset_n` at sweep cycle 4 → all outputs 0 with no `done` pulse. A following load and step behave normally.
